// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bundle: decoded ID-stage controls and operands in,
// registered EX-stage copies out, plus the stall/flush controls and status.
//
// Valid/ready semantics: there is no backpressure handshake here. Each rising
// clk edge moves the ID bundle into EX unless Stall holds it or Flush replaces
// it with a bubble. Valid_ID_EX marks a real (non-bubble) instruction in EX.
interface id_ex_reg_if;
  // ID-stage controls
  logic        RegDst;
  logic        Reg_Write;
  logic        ALUSrc;
  logic        PcSrc;
  logic        Mem_Write;
  logic        Mem_to_Reg;
  logic        Mem_Read;
  logic        Jump;
  logic [3:0]  ALUOp;
  // ID-stage data
  logic [31:0] PC_plus4_ID;
  logic [31:0] Read_data1_ID;
  logic [31:0] Read_data2_ID;
  logic [31:0] Imm_ext_ID;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic [4:0]  Rd_ID;
  logic [5:0]  Funct_ID;
  // pipeline control
  logic        Stall;
  logic        Flush;
  // EX-stage registered copies
  logic        RegDst_ID_EX;
  logic        Reg_Write_ID_EX;
  logic        ALUSrc_ID_EX;
  logic        PcSrc_ID_EX;
  logic        Mem_Write_ID_EX;
  logic        Mem_to_Reg_ID_EX;
  logic        Mem_Read_ID_EX;
  logic        Jump_ID_EX;
  logic [3:0]  ALUOp_ID_EX;
  logic [31:0] PC_plus4_ID_EX;
  logic [31:0] Read_data1_ID_EX;
  logic [31:0] Read_data2_ID_EX;
  logic [31:0] Imm_ext_ID_EX;
  logic [4:0]  Rs_ID_EX;
  logic [4:0]  Rt_ID_EX;
  logic [4:0]  Rd_ID_EX;
  logic [5:0]  Funct_ID_EX;
  logic        Valid_ID_EX;
  // status
  logic        Load_use_hazard;
  logic [15:0] Bubble_cnt;

  modport master (
    output RegDst, Reg_Write, ALUSrc, PcSrc, Mem_Write, Mem_to_Reg, Mem_Read, Jump, ALUOp,
    output PC_plus4_ID, Read_data1_ID, Read_data2_ID, Imm_ext_ID, Rs_ID, Rt_ID, Rd_ID, Funct_ID,
    output Stall, Flush,
    input  RegDst_ID_EX, Reg_Write_ID_EX, ALUSrc_ID_EX, PcSrc_ID_EX, Mem_Write_ID_EX,
    input  Mem_to_Reg_ID_EX, Mem_Read_ID_EX, Jump_ID_EX, ALUOp_ID_EX,
    input  PC_plus4_ID_EX, Read_data1_ID_EX, Read_data2_ID_EX, Imm_ext_ID_EX,
    input  Rs_ID_EX, Rt_ID_EX, Rd_ID_EX, Funct_ID_EX, Valid_ID_EX,
    input  Load_use_hazard, Bubble_cnt
  );

  modport slave (
    input  RegDst, Reg_Write, ALUSrc, PcSrc, Mem_Write, Mem_to_Reg, Mem_Read, Jump, ALUOp,
    input  PC_plus4_ID, Read_data1_ID, Read_data2_ID, Imm_ext_ID, Rs_ID, Rt_ID, Rd_ID, Funct_ID,
    input  Stall, Flush,
    output RegDst_ID_EX, Reg_Write_ID_EX, ALUSrc_ID_EX, PcSrc_ID_EX, Mem_Write_ID_EX,
    output Mem_to_Reg_ID_EX, Mem_Read_ID_EX, Jump_ID_EX, ALUOp_ID_EX,
    output PC_plus4_ID_EX, Read_data1_ID_EX, Read_data2_ID_EX, Imm_ext_ID_EX,
    output Rs_ID_EX, Rt_ID_EX, Rd_ID_EX, Funct_ID_EX, Valid_ID_EX,
    output Load_use_hazard, Bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble, load-use hazard
// detection and an optional saturating bubble counter.
// Optional feature macro: ID_EX_BUBBLE_CNT_EN (when undefined Bubble_cnt = 0).
// No FSM: state is the field bundle, the valid bit and (optionally) the counter.
module id_ex_reg (
  input logic         clk,
  input logic         rst,
  id_ex_reg_if.slave  bus
);

  localparam int BUNDLE_W = 8 + 4 + 4*32 + 3*5 + 6;

  logic [BUNDLE_W-1:0] w_in;
  logic [BUNDLE_W-1:0] r_bundle;
  logic                r_valid;
  logic                w_rt_match;

  // all ID fields gathered so the hold/flush/load rule applies uniformly
  assign w_in = {bus.RegDst, bus.Reg_Write, bus.ALUSrc, bus.PcSrc,
                 bus.Mem_Write, bus.Mem_to_Reg, bus.Mem_Read, bus.Jump,
                 bus.ALUOp, bus.PC_plus4_ID, bus.Read_data1_ID,
                 bus.Read_data2_ID, bus.Imm_ext_ID, bus.Rs_ID, bus.Rt_ID,
                 bus.Rd_ID, bus.Funct_ID};

  // field register: reset > flush (bubble) > stall (hold) > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bundle <= '0;
      r_valid  <= 1'b0;
    end else if (bus.Flush) begin
      r_bundle <= '0;
      r_valid  <= 1'b0;
    end else if (!bus.Stall) begin
      r_bundle <= w_in;
      r_valid  <= 1'b1;
    end
  end

  assign {bus.RegDst_ID_EX, bus.Reg_Write_ID_EX, bus.ALUSrc_ID_EX, bus.PcSrc_ID_EX,
          bus.Mem_Write_ID_EX, bus.Mem_to_Reg_ID_EX, bus.Mem_Read_ID_EX, bus.Jump_ID_EX,
          bus.ALUOp_ID_EX, bus.PC_plus4_ID_EX, bus.Read_data1_ID_EX,
          bus.Read_data2_ID_EX, bus.Imm_ext_ID_EX, bus.Rs_ID_EX, bus.Rt_ID_EX,
          bus.Rd_ID_EX, bus.Funct_ID_EX} = r_bundle;
  assign bus.Valid_ID_EX = r_valid;

  // a load in EX whose destination (Rt) feeds the instruction now in ID;
  // register $0 never creates a dependency
  assign w_rt_match = (bus.Rt_ID_EX == bus.Rs_ID) || (bus.Rt_ID_EX == bus.Rt_ID);
  assign bus.Load_use_hazard = r_valid && bus.Mem_Read_ID_EX &&
                               (bus.Rt_ID_EX != 5'd0) && w_rt_match;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  // one count per flushed edge, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= 16'h0000;
    end else if (bus.Flush && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bus.Bubble_cnt = r_bubble_cnt;
`else
  assign bus.Bubble_cnt = 16'h0000;
`endif

endmodule
